// File: rtl/s_ct_update.sv
// LSTM cell-state update: Ct = f*(Ct-1) + i*g, computed elementwise in a
// two-stage valid/ready pipeline with element indexing and sticky saturation.
module s_ct_update #(
  parameter int          N_CELL     = 32,
  parameter logic [7:0]  ZERO_STATE = 8'd128,
  parameter logic [7:0]  ZERO_TANH  = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] f_q,
  input  logic [7:0] i_q,
  input  logic [7:0] g_q,
  input  logic [7:0] cp_q,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] ct_q,
  output logic [7:0] out_idx,
  output logic       out_last,
  output logic       sat_flag,
  input  logic       sat_clr
);

  localparam logic [7:0] LAST_IDX = 8'(N_CELL - 1);

  logic               en;
  logic               out_xfer;

  // S1 state: products of each gate with its zero-centred operand
  logic               s1_valid_reg;
  logic signed [16:0] pf_reg;
  logic signed [16:0] pi_reg;
  logic signed [16:0] pf_next;
  logic signed [16:0] pi_next;

  // S2 state: clamped result presented downstream
  logic               s2_valid_reg;
  logic [7:0]         ct_reg;
  logic               s2_sat_reg;
  logic [7:0]         ct_next;
  logic               sat_next;

  logic [7:0]         idx_reg;
  logic               sat_flag_reg;

  // Stage-1 arithmetic
  logic signed [8:0]  cp_diff;
  logic signed [8:0]  g_diff;
  logic signed [8:0]  f_s;
  logic signed [8:0]  i_s;
  logic signed [17:0] pf_full;
  logic signed [17:0] pi_full;

  // Stage-2 arithmetic
  logic signed [17:0] sum;
  logic signed [17:0] quot;
  logic signed [18:0] r_full;

  assign en       = !s2_valid_reg || out_ready;
  assign in_ready = en;
  assign out_xfer = s2_valid_reg && out_ready;

  always_comb begin
    cp_diff = $signed({1'b0, cp_q}) - $signed({1'b0, ZERO_STATE});
    g_diff  = $signed({1'b0, g_q})  - $signed({1'b0, ZERO_TANH});
    f_s     = $signed({1'b0, f_q});
    i_s     = $signed({1'b0, i_q});
    pf_full = f_s * cp_diff;
    pi_full = i_s * g_diff;
    // |product| <= 255*128, so 17 signed bits always hold it exactly
    pf_next = pf_full[16:0];
    pi_next = pi_full[16:0];
  end

  always_comb begin
    sum    = {pf_reg[16], pf_reg} + {pi_reg[16], pi_reg};
    // Signed division truncates toward zero, unlike an arithmetic shift
    quot   = sum / 18'sd256;
    r_full = {quot[17], quot} + $signed({11'd0, ZERO_STATE});
    ct_next  = r_full[7:0];
    sat_next = 1'b0;
    if (r_full < 19'sd0) begin
      ct_next  = 8'd0;
      sat_next = 1'b1;
    end else if (r_full > 19'sd255) begin
      ct_next  = 8'd255;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      pf_reg       <= '0;
      pi_reg       <= '0;
      s2_valid_reg <= 1'b0;
      ct_reg       <= 8'd0;
      s2_sat_reg   <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      pf_reg       <= pf_next;
      pi_reg       <= pi_next;
      s2_valid_reg <= s1_valid_reg;
      ct_reg       <= ct_next;
      s2_sat_reg   <= sat_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= 8'd0;
    end else if (out_xfer) begin
      idx_reg <= (idx_reg == LAST_IDX) ? 8'd0 : idx_reg + 8'd1;
    end
  end

  // A saturating transfer takes priority over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag_reg <= 1'b0;
    end else if (out_xfer && s2_sat_reg) begin
      sat_flag_reg <= 1'b1;
    end else if (sat_clr) begin
      sat_flag_reg <= 1'b0;
    end
  end

  assign out_valid = s2_valid_reg;
  assign ct_q      = ct_reg;
  assign out_idx   = idx_reg;
  assign out_last  = s2_valid_reg && (idx_reg == LAST_IDX);
  assign sat_flag  = sat_flag_reg;

endmodule

// File: tb/tb_s_ct_update.sv
// Directed bench for s_ct_update: hand-computed scenarios, reset behaviour,
// and a stalled stream checked against an arithmetic reference.
module tb_s_ct_update;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] f_q, i_q, g_q, cp_q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ct_q;
  logic [7:0] out_idx;
  logic       out_last;
  logic       sat_flag;
  logic       sat_clr;

  int errors = 0;
  int checks = 0;

  s_ct_update #(.N_CELL(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .f_q(f_q), .i_q(i_q), .g_q(g_q), .cp_q(cp_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .ct_q(ct_q), .out_idx(out_idx), .out_last(out_last),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one element at a negedge; it is accepted on the next posedge
  task automatic push(input logic [7:0] f, input logic [7:0] i,
                      input logic [7:0] g, input logic [7:0] cp);
    f_q = f; i_q = i; g_q = g; cp_q = cp;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] ref_ct(input int f, input int i, input int g, input int cp);
    int s, r;
    s = f * (cp - 128) + i * (g - 128);
    r = s / 256 + 128;
    if (r < 0) return 8'd0;
    if (r > 255) return 8'd255;
    return 8'(r);
  endfunction

  logic [7:0] exp_q[$];
  int sent, recv, exp_idx, cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    f_q = 8'd0; i_q = 8'd0; g_q = 8'd0; cp_q = 8'd0;
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ct_q", 32'(ct_q), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // f=128, cp=192, i=0 -> 8192/256+128 = 160
    push(8'd128, 8'd0, 8'd77, 8'd192);
    chk("s40_lat1_valid", 32'(out_valid), 32'd0);
    step();
    chk("s40_lat2_valid", 32'(out_valid), 32'd1);
    chk("s40_ct", 32'(ct_q), 32'd160);
    chk("s40_idx", 32'(out_idx), 32'd0);
    chk("s40_last", 32'(out_last), 32'd0);
    step();
    chk("s40_drained", 32'(out_valid), 32'd0);
    chk("s40_sat", 32'(sat_flag), 32'd0);
    chk("s40_idx_next", 32'(out_idx), 32'd1);

    // Max positive: sum 64770, r=381 -> 255, saturates
    push(8'd255, 8'd255, 8'd255, 8'd255);
    step();
    chk("s41_ct", 32'(ct_q), 32'd255);
    chk("s41_idx", 32'(out_idx), 32'd1);
    step();
    chk("s41_sat", 32'(sat_flag), 32'd1);

    // Max negative with clear held: set wins on the transfer, clear afterwards
    sat_clr = 1'b1;
    push(8'd255, 8'd255, 8'd0, 8'd0);
    chk("s42_cleared_early", 32'(sat_flag), 32'd0);
    step();
    chk("s42_ct", 32'(ct_q), 32'd0);
    step();
    chk("s42_set_wins", 32'(sat_flag), 32'd1);
    step();
    chk("s42_clear", 32'(sat_flag), 32'd0);
    sat_clr = 1'b0;

    // sum=-127 truncates toward zero -> 128
    push(8'd1, 8'd0, 8'd0, 8'd1);
    step();
    chk("s43_ct", 32'(ct_q), 32'd128);
    chk("s43_idx", 32'(out_idx), 32'd3);
    step();
    chk("s43_idx_next", 32'(out_idx), 32'd4);

    // Stall with one element held: output and index must not move
    out_ready = 1'b0;
    push(8'd128, 8'd0, 8'd0, 8'd64);
    step();
    step();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_ct", 32'(ct_q), 32'd96);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("stall_ct_held", 32'(ct_q), 32'd96);
    chk("stall_idx_held", 32'(out_idx), 32'd4);
    out_ready = 1'b1;
    step();
    chk("stall_released", 32'(out_valid), 32'd0);
    chk("stall_idx_next", 32'(out_idx), 32'd5);

    // Reset with two elements in flight
    f_q = 8'd128; i_q = 8'd0; g_q = 8'd0; cp_q = 8'd200;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_idx", 32'(out_idx), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    push(8'd128, 8'd0, 8'd0, 8'd160);
    chk("rst_flush_s1", 32'(out_valid), 32'd0);
    step();
    chk("rst_first_valid", 32'(out_valid), 32'd1);
    chk("rst_first_idx", 32'(out_idx), 32'd0);
    chk("rst_first_ct", 32'(ct_q), 32'd144);
    step();
    chk("rst_no_stale", 32'(out_valid), 32'd0);

    // Restart the index, then stream N+3 elements with bubbles and stalls
    rst = 1'b1;
    step();
    rst = 1'b0;
    sent = 0; recv = 0; exp_idx = 0; cyc = 0;
    while (recv < N + 3 && cyc < 2000) begin
      if (out_valid === 1'b1) begin
        chk("stream_ct", 32'(ct_q), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hDEAD);
        chk("stream_idx", 32'(out_idx), 32'(exp_idx));
      end
      chk("stream_last", 32'(out_last), 32'((out_valid === 1'b1) && (exp_idx == N - 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < N + 3) && ($urandom_range(0, 4) != 0);
      f_q = 8'($urandom_range(0, 255)); i_q = 8'($urandom_range(0, 255));
      g_q = 8'($urandom_range(0, 255)); cp_q = 8'($urandom_range(0, 255));
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'((out_valid !== 1'b1) || out_ready));
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_idx = (exp_idx + 1) % N;
        recv++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(ref_ct(f_q, i_q, g_q, cp_q));
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_all_received", 32'(recv), 32'(N + 3));
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    step();
    step();
    chk("stream_no_extra", 32'(out_valid), 32'd0);
    chk("stream_final_idx", 32'(out_idx), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s_ct_update.md
S_CT_UPDATE -- requirements
Module: s_ct_update

Interface
REQ-001 Parameter N_CELL, default 32: number of cell elements per vector, legal range 2..256.
REQ-002 Parameter ZERO_STATE, default 8'd128: zero point of Ct_prev and Ct_out; scale is 128.
REQ-003 Parameter ZERO_TANH, default 8'd128: zero point of the tanh gate g; scale is 128.
REQ-004 Sigmoid gates f and i have scale 256 and zero 0.
REQ-005 clk  in  1  single clock; all registers update on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  the input element is valid.
REQ-008 in_ready  out  1  the block accepts the input element this cycle.
REQ-009 f_q  in  8  forget-gate sigmoid output.
REQ-010 i_q  in  8  input-gate sigmoid output.
REQ-011 g_q  in  8  candidate tanh output.
REQ-012 cp_q  in  8  previous cell state Ct-1.
REQ-013 out_valid  out  1  the Ct result is valid.
REQ-014 out_ready  in  1  the downstream stage (Sys_Ct consumer) accepts the result.
REQ-015 ct_q  out  8  new cell state Ct, passed downstream as Sys_Ct.
REQ-016 out_idx  out  8  element index of ct_q, in the range 0..N_CELL-1.
REQ-017 out_last  out  1  high together with out_valid when out_idx equals N_CELL-1.
REQ-018 sat_flag  out  1  sticky; set when any result saturated since reset or clear.
REQ-019 sat_clr  in  1  synchronous clear of sat_flag.

Function
REQ-020 The block is a 2-stage pipeline with stages S1 and S2, each with its own valid bit.
REQ-021 The pipeline advance enable is en = !out_valid || out_ready.
REQ-022 in_ready SHALL equal en; a transfer occurs on in_valid && in_ready.
REQ-023 When en is high, S1 captures the signed 17-bit products pf = f_q*(cp_q-ZERO_STATE) and pi = i_q*(g_q-ZERO_TANH), and the S1 valid bit captures in_valid.
REQ-024 When en is high, S2 captures the S1 result and the S2 valid bit captures the S1 valid bit.
REQ-025 S2 computes sum = pf+pi as a signed 18-bit value, then q = sum/256 with truncation toward zero, then r = q + ZERO_STATE.
REQ-026 ct_q SHALL be 0 if r<0, 255 if r>255, and r[7:0] otherwise; saturation is evaluated on the full-width value.
REQ-027 The latency from an accepted input to out_valid is exactly 2 cycles when out_ready stays high.
REQ-028 Sustained throughput is 1 element per cycle.
REQ-029 When en is low, S1, S2, ct_q, out_idx and out_last SHALL hold their values.
REQ-030 out_valid SHALL remain high until out_ready is sampled high.
REQ-031 No element SHALL be dropped or duplicated under any out_ready pattern.
REQ-032 The index counter increments on each output transfer (out_valid && out_ready).
REQ-033 The index counter wraps from N_CELL-1 to 0; out_idx shows the counter value.
REQ-034 Input bubbles (in_valid low) propagate as invalid slots and do not advance the index counter.
REQ-035 sat_flag sets when a transfer occurs on an S2 result that saturated.
REQ-036 When sat_clr and a saturating transfer occur in the same cycle, set wins.

Reset
REQ-037 While rst is high, all state clears immediately: S1 and S2 valid bits 0, out_valid 0, ct_q 0, out_idx 0, out_last 0, sat_flag 0.
REQ-038 in_ready SHALL be 1 during reset and on the first cycle after reset.
REQ-039 Reset during operation discards all in-flight elements, and the index restarts at 0.

Verification
REQ-040 Scenario: f=128, cp=192, i=0, g=any -> sum=8192, ct_q=160, out_valid 2 cycles after acceptance, sat_flag 0.
REQ-041 Scenario: f=255, cp=255, i=255, g=255 -> sum=64770, r=381, ct_q=255, sat_flag=1.
REQ-042 Scenario: f=255, cp=0, i=255, g=0 -> sum=-65280, ct_q=0, sat_flag=1; then sat_clr -> sat_flag=0.
REQ-043 Scenario: f=1, cp=1, i=0 -> sum=-127, q=0 (truncation toward zero), ct_q=128.
REQ-044 Scenario: stream N_CELL+3 elements with random out_ready stalls -> every result in order, out_idx sequence 0..N_CELL-1,0,1,2, out_last only at idx N_CELL-1, and ct_q stable while stalled.
REQ-045 Scenario: assert rst with 2 elements in flight -> out_valid=0 immediately; the next accepted element emerges with out_idx=0.
